mem_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter and access sequencer for the 16x32 single-port memory. It accepts read/write requests from requesters A and B over valid/ready handshakes and issues at most one memory access per cycle from registered memory-side outputs. It returns registered read data to the requester that issued the read. It sits directly between the two client blocks and the memory's en/wen/Addr/Data_in/Data_out/Valid pins.

---
 rtl/mem_rr_arbiter_if.sv | 79 +++++++
 rtl/mem_rr_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter_if
//
// Bundles every non-clock/non-reset signal of mem_rr_arbiter: the two requester
// command/response channels, the memory-side pins and the status outputs.
//
//   slave  modport : seen by the arbiter (takes requests, drives the memory).
//   master modport : seen by the surroundings (requesters + memory model).
//
// Requester channel (x = a, b):
//   x_req_valid  command present          x_req_ready  command accepted
//   x_req_wen    1 = write, 0 = read      x_req_addr   target address
//   x_req_wdata  write data               x_rsp_valid  one-cycle read strobe
//   x_rsp_rdata  read data (held between strobes)
// Memory side:
//   mem_en / mem_wen / mem_addr / mem_wdata  registered access to the memory
//   mem_rdata / mem_valid                    combinational memory read return
// Status:
//   rd_err        pulse when an issued read saw mem_valid = 0
//   x_grant_cnt   saturating count of accepted commands per requester
// -----------------------------------------------------------------------------
interface mem_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  // requester A
  logic                  a_req_valid;
  logic                  a_req_ready;
  logic                  a_req_wen;
  logic [ADDR_WIDTH-1:0] a_req_addr;
  logic [DATA_WIDTH-1:0] a_req_wdata;
  logic                  a_rsp_valid;
  logic [DATA_WIDTH-1:0] a_rsp_rdata;

  // requester B
  logic                  b_req_valid;
  logic                  b_req_ready;
  logic                  b_req_wen;
  logic [ADDR_WIDTH-1:0] b_req_addr;
  logic [DATA_WIDTH-1:0] b_req_wdata;
  logic                  b_rsp_valid;
  logic [DATA_WIDTH-1:0] b_rsp_rdata;

  // memory pins
  logic                  mem_en;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_valid;

  // status
  logic                  rd_err;
  logic [CNT_WIDTH-1:0]  a_grant_cnt;
  logic [CNT_WIDTH-1:0]  b_grant_cnt;

  modport slave (
    input  a_req_valid, a_req_wen, a_req_addr, a_req_wdata,
    output a_req_ready, a_rsp_valid, a_rsp_rdata,
    input  b_req_valid, b_req_wen, b_req_addr, b_req_wdata,
    output b_req_ready, b_rsp_valid, b_rsp_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_valid,
    output rd_err, a_grant_cnt, b_grant_cnt
  );

  modport master (
    output a_req_valid, a_req_wen, a_req_addr, a_req_wdata,
    input  a_req_ready, a_rsp_valid, a_rsp_rdata,
    output b_req_valid, b_req_wen, b_req_addr, b_req_wdata,
    input  b_req_ready, b_rsp_valid, b_rsp_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_valid,
    input  rd_err, a_grant_cnt, b_grant_cnt
  );

endinterface

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
//
// Two-requester round-robin arbiter and access sequencer for a 16x32
// single-port memory with combinational read.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   mem_rr_arbiter_if.slave -- requester A/B command and response
//         channels, memory pins, rd_err pulse and per-requester grant counters
//
// Pipeline:
//   cycle N   : combinational grant on the current valids, command accepted
//   cycle N+1 : registered memory access (mem_en high); read data is returned
//               combinationally by the memory and captured at the closing edge
//   cycle N+2 : owner's rsp_valid strobe (+ rd_err if the memory flagged it)
// One command is accepted every cycle at least one requester is valid.
// -----------------------------------------------------------------------------
module mem_rr_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  mem_rr_arbiter_if.slave bus
);

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_WIDTH'(1);
  endfunction

  // Round-robin pick. On a tie the requester that did not win last time goes.
  // Returns {grant_b, grant_a}.
  function automatic logic [1:0] rr_pick(input logic a_v, input logic b_v, input gnt_e last);
    logic [1:0] g;
    g = 2'b00;
    if (a_v && b_v) begin
      g = (last == GNT_B) ? 2'b01 : 2'b10;
    end else begin
      g = {b_v, a_v};
    end
    return g;
  endfunction

  gnt_e                  last_grant;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  accept;
  logic                  sel_wen;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  vld_p0;
  logic                  wen_p0;
  logic                  rd_p0;
  logic                  own_b_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;

  logic                  a_vld_p1;
  logic                  b_vld_p1;
  logic                  err_p1;
  logic [DATA_WIDTH-1:0] a_rdata_p1;
  logic [DATA_WIDTH-1:0] b_rdata_p1;

  logic [CNT_WIDTH-1:0]  a_cnt;
  logic [CNT_WIDTH-1:0]  b_cnt;

  // Stage: request arbitration (combinational, cycle N).
  // Ready is gated by rstn so nothing is accepted while reset is held.
  always_comb begin
    logic [1:0] pick;
    pick  = rr_pick(bus.a_req_valid, bus.b_req_valid, last_grant);
    gnt_a = rstn & pick[0];
    gnt_b = rstn & pick[1];
  end

  assign accept = gnt_a | gnt_b;

  always_comb begin
    sel_wen   = bus.a_req_wen;
    sel_addr  = bus.a_req_addr;
    sel_wdata = bus.a_req_wdata;
    if (gnt_b) begin
      sel_wen   = bus.b_req_wen;
      sel_addr  = bus.b_req_addr;
      sel_wdata = bus.b_req_wdata;
    end
  end

  assign bus.a_req_ready = gnt_a;
  assign bus.b_req_ready = gnt_b;

  // Stage p0: registered memory access (cycle N+1).
  // Address/data hold their last value when idle; only en/wen drop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0   <= 1'b0;
      wen_p0   <= 1'b0;
      rd_p0    <= 1'b0;
      own_b_p0 <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else begin
      vld_p0 <= accept;
      wen_p0 <= accept & sel_wen;
      rd_p0  <= accept & ~sel_wen;
      if (accept) begin
        own_b_p0 <= gnt_b;
        addr_p0  <= sel_addr;
        wdata_p0 <= sel_wdata;
      end
    end
  end

  assign bus.mem_en    = vld_p0;
  assign bus.mem_wen   = wen_p0;
  assign bus.mem_addr  = addr_p0;
  assign bus.mem_wdata = wdata_p0;

  // Stage p1: read response (cycle N+2).
  // The memory read is combinational, so the data present during the issue
  // cycle is captured at its closing edge. The non-owner's data register holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_vld_p1   <= 1'b0;
      b_vld_p1   <= 1'b0;
      err_p1     <= 1'b0;
      a_rdata_p1 <= '0;
      b_rdata_p1 <= '0;
    end else begin
      a_vld_p1 <= rd_p0 & ~own_b_p0;
      b_vld_p1 <= rd_p0 & own_b_p0;
      err_p1   <= rd_p0 & ~bus.mem_valid;
      if (rd_p0 && !own_b_p0) begin
        a_rdata_p1 <= bus.mem_rdata;
      end
      if (rd_p0 && own_b_p0) begin
        b_rdata_p1 <= bus.mem_rdata;
      end
    end
  end

  assign bus.a_rsp_valid = a_vld_p1;
  assign bus.b_rsp_valid = b_vld_p1;
  assign bus.a_rsp_rdata = a_rdata_p1;
  assign bus.b_rsp_rdata = b_rdata_p1;
  assign bus.rd_err      = err_p1;

  // Arbitration state and grant counters; both move only on an accepted command.
  // last_grant resets to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= GNT_B;
      a_cnt      <= '0;
      b_cnt      <= '0;
    end else begin
      if (gnt_a) begin
        last_grant <= GNT_A;
        a_cnt      <= sat_inc(a_cnt);
      end else if (gnt_b) begin
        last_grant <= GNT_B;
        b_cnt      <= sat_inc(b_cnt);
      end
    end
  end

  assign bus.a_grant_cnt = a_cnt;
  assign bus.b_grant_cnt = b_cnt;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rr_arbiter
//
// Scoreboard bench for mem_rr_arbiter. Stimulus pushes the expected memory
// access and (for reads) the expected response, each stamped with the cycle
// it must appear in; monitors on the falling edge pop and compare whenever
// mem_en or an rsp_valid is seen. A second instance built with CNT_WIDTH=2
// exercises counter saturation. The memory is a small behavioural model of the
// 16x32 part (write on clock edge, combinational read, Valid only on reads).
// -----------------------------------------------------------------------------
module tb_mem_rr_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  mem_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2))  bus2 ();

  mem_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  mem_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) u_sat (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2.slave)
  );

  // memory model
  logic [DW-1:0] mem_arr [16];
  logic          mem_ok;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wen) mem_arr[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_valid = bus.mem_en && !bus.mem_wen && mem_ok;
  assign bus.mem_rdata = bus.mem_valid ? mem_arr[bus.mem_addr] : '0;

  assign bus2.mem_valid = 1'b1;
  assign bus2.mem_rdata = '0;

  // bookkeeping
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            at;
  } iss_t;

  typedef struct {
    logic          own_b;
    logic [DW-1:0] rdata;
    logic          err;
    int            at;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitors
  iss_t ie_m;
  rsp_t re_m;

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (iss_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL mem_issue: unexpected access addr 0x%0h wen %0b (cycle %0d)",
                 bus.mem_addr, bus.mem_wen, cyc);
      end else begin
        ie_m = iss_q.pop_front();
        chk("iss_cycle", 64'(cyc), 64'(ie_m.at));
        chk("iss_wen", 64'(bus.mem_wen), 64'(ie_m.wen));
        chk("iss_addr", 64'(bus.mem_addr), 64'(ie_m.addr));
        if (ie_m.wen) chk("iss_wdata", 64'(bus.mem_wdata), 64'(ie_m.wdata));
      end
    end

    if (bus.a_rsp_valid === 1'b1 || bus.b_rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rsp: unexpected response a=%0b b=%0b (cycle %0d)",
                 bus.a_rsp_valid, bus.b_rsp_valid, cyc);
      end else begin
        re_m = rsp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(re_m.at));
        chk("rsp_both", 64'(bus.a_rsp_valid & bus.b_rsp_valid), 64'(0));
        chk("rsp_owner_b", 64'(bus.b_rsp_valid), 64'(re_m.own_b));
        if (re_m.own_b) chk("b_rsp_rdata", 64'(bus.b_rsp_rdata), 64'(re_m.rdata));
        else            chk("a_rsp_rdata", 64'(bus.a_rsp_rdata), 64'(re_m.rdata));
        chk("rd_err", 64'(bus.rd_err), 64'(re_m.err));
      end
    end else if (bus.rd_err === 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL rd_err: pulse without response (cycle %0d)", cyc);
    end
  end

  // one cycle of stimulus; eg = expected grant (0 none, 1 A, 2 B)
  task automatic step(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input int eg, input logic [DW-1:0] erd, input logic eerr);
    iss_t ie;
    rsp_t re;
    @(posedge clk);
    #1;
    bus.a_req_valid = av; bus.a_req_wen = aw; bus.a_req_addr = aa; bus.a_req_wdata = ad;
    bus.b_req_valid = bv; bus.b_req_wen = bw; bus.b_req_addr = ba; bus.b_req_wdata = bd;
    if (eg != 0) begin
      ie.wen   = (eg == 1) ? aw : bw;
      ie.addr  = (eg == 1) ? aa : ba;
      ie.wdata = (eg == 1) ? ad : bd;
      ie.at    = cyc + 1;
      iss_q.push_back(ie);
      if (!ie.wen) begin
        re.own_b = (eg == 2);
        re.rdata = erd;
        re.err   = eerr;
        re.at    = cyc + 2;
        rsp_q.push_back(re);
      end
    end
    @(negedge clk);
    chk("a_req_ready", 64'(bus.a_req_ready), 64'(eg == 1));
    chk("b_req_ready", 64'(bus.b_req_ready), 64'(eg == 2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 0, '0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_ready"}, 64'(bus.a_req_ready), 64'(0));
    chk({tag, "_b_ready"}, 64'(bus.b_req_ready), 64'(0));
    chk({tag, "_mem_en"}, 64'(bus.mem_en), 64'(0));
    chk({tag, "_mem_wen"}, 64'(bus.mem_wen), 64'(0));
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    chk({tag, "_a_rsp_valid"}, 64'(bus.a_rsp_valid), 64'(0));
    chk({tag, "_b_rsp_valid"}, 64'(bus.b_rsp_valid), 64'(0));
    chk({tag, "_a_rsp_rdata"}, 64'(bus.a_rsp_rdata), 64'(0));
    chk({tag, "_b_rsp_rdata"}, 64'(bus.b_rsp_rdata), 64'(0));
    chk({tag, "_rd_err"}, 64'(bus.rd_err), 64'(0));
    chk({tag, "_a_cnt"}, 64'(bus.a_grant_cnt), 64'(0));
    chk({tag, "_b_cnt"}, 64'(bus.b_grant_cnt), 64'(0));
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rstn   = 1'b0;
    mem_ok = 1'b1;
    bus.a_req_valid = 1'b1; bus.a_req_wen = 1'b0; bus.a_req_addr = '0; bus.a_req_wdata = '0;
    bus.b_req_valid = 1'b1; bus.b_req_wen = 1'b0; bus.b_req_addr = '0; bus.b_req_wdata = '0;
    bus2.a_req_valid = 1'b0; bus2.a_req_wen = 1'b1; bus2.a_req_addr = 4'h1; bus2.a_req_wdata = 32'h1;
    bus2.b_req_valid = 1'b0; bus2.b_req_wen = 1'b0; bus2.b_req_addr = '0;   bus2.b_req_wdata = '0;

    // reset state, with both valids high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");

    @(posedge clk);
    #1;
    bus.a_req_valid = 1'b0;
    bus.b_req_valid = 1'b0;
    rstn = 1'b1;

    // A write 3 = DEADBEEF, then A read-after-write of 3
    step(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, 1, '0, 1'b0);
    step(1'b1, 1'b0, 4'd3, 32'h0,        1'b0, 1'b0, '0, '0, 1, 32'hDEADBEEF, 1'b0);
    chk("a_cnt_after_write", 64'(bus.a_grant_cnt), 64'(1));
    idle(3);
    chk("a_cnt_after_raw", 64'(bus.a_grant_cnt), 64'(2));

    // B preload 0..5 = 0x10..0x15, then stream reads 0..5
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), DW'(32'h10 + i), 2, '0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0, 2, DW'(32'h10 + i), 1'b0);
    idle(3);
    chk("b_cnt_after_stream", 64'(bus.b_grant_cnt), 64'(12));

    // read while memory reports not-valid -> rdata 0 with rd_err
    mem_ok = 1'b0;
    step(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, '0, '0, 1, 32'h0, 1'b1);
    idle(2);
    mem_ok = 1'b1;
    chk("b_rdata_holds", 64'(bus.b_rsp_rdata), 64'(32'h15));
    chk("a_cnt_after_err", 64'(bus.a_grant_cnt), 64'(3));

    // reset mid-flight: A read accepted, reset in the issue cycle
    step(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, '0, '0, 1, 32'hDEADBEEF, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    iss_q.delete();
    rsp_q.delete();
    bus.a_req_valid = 1'b1;
    bus.b_req_valid = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk("midrst_no_rsp", 64'(bus.a_rsp_valid), 64'(0));
    chk("midrst_no_err", 64'(bus.rd_err), 64'(0));
    @(posedge clk);
    #1;
    bus.a_req_valid = 1'b0;
    bus.b_req_valid = 1'b0;
    rstn = 1'b1;

    // contention after release: A reads 0, B reads 1 -> grants A,B,A,B
    step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd1, '0, 1, 32'h10, 1'b0);
    step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd1, '0, 2, 32'h11, 1'b0);
    step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd1, '0, 1, 32'h10, 1'b0);
    step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd1, '0, 2, 32'h11, 1'b0);
    idle(3);
    chk("a_cnt_contention", 64'(bus.a_grant_cnt), 64'(2));
    chk("b_cnt_contention", 64'(bus.b_grant_cnt), 64'(2));

    // saturation on the CNT_WIDTH=2 instance: 5 writes from A
    @(posedge clk);
    #1;
    bus2.a_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) bus2.a_req_valid = 1'b0;
      @(negedge clk);
      chk("sat_a_cnt", 64'(bus2.a_grant_cnt), 64'(sat_exp[k]));
    end

    idle(2);
    chk("iss_q_drained", 64'(iss_q.size()), 64'(0));
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
